// File: rtl/synapse_loader_if.sv
// Config handshake and spike/wx bus between the IO path and synapse_loader.
// master drives weights and spikes; slave returns ready/done/busy and the wx bus.
interface synapse_loader_if #(
   parameter int N_STAGE = 5
);
   localparam int N_SYN = 2**N_STAGE;

   logic                 cfg_start;
   logic                 cfg_valid;
   logic [1:0]           cfg_data;
   logic                 cfg_ready;
   logic                 cfg_done;
   logic                 busy;
   logic                 spike_valid;
   logic [N_SYN-1:0]     spike_in;
   logic [2*N_SYN-1:0]   wx;
   logic                 wx_valid;

   modport master (
      output cfg_start, cfg_valid, cfg_data, spike_valid, spike_in,
      input  cfg_ready, cfg_done, busy, wx, wx_valid
   );

   modport slave (
      input  cfg_start, cfg_valid, cfg_data, spike_valid, spike_in,
      output cfg_ready, cfg_done, busy, wx, wx_valid
   );
endinterface

// File: rtl/synapse_loader.sv
// Serial weight load into a shadow bank with atomic commit; spikes gated onto wx 1 edge later.
// cfg_ready only in LOAD (cfg_valid gaps stall indefinitely); spike path never stalls.
module synapse_loader #(
   parameter int N_STAGE = 5
) (
   input logic              clk,
   input logic              rst_n,
   synapse_loader_if.slave  bus
);
   localparam int N_SYN = 2**N_STAGE;
   localparam logic [N_STAGE-1:0] IDX_LAST = '1;

   typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

   state_t                   state_q, state_d;
   logic [N_STAGE-1:0]       idx_q, idx_d;
   logic [N_SYN-1:0][1:0]    w_shadow_q;
   logic [N_SYN-1:0][1:0]    w_active_q;
   logic [2*N_SYN-1:0]       wx_q, wx_d;
   logic                     wx_valid_q;
   logic                     cfg_done_q;
   logic                     shadow_we;
   logic                     commit;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      shadow_we = 1'b0;
      commit    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.cfg_start) begin
               idx_d   = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            // A restart wins over a concurrent transfer, which is dropped.
            if (bus.cfg_start) begin
               idx_d = '0;
            end else if (bus.cfg_valid) begin
               shadow_we = 1'b1;
               idx_d     = idx_q + N_STAGE'(1);
               if (idx_q == IDX_LAST) begin
                  state_d = COMMIT;
               end
            end
         end
         COMMIT: begin
            commit  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wx_d = '0;
      for (int k = 0; k < N_SYN; k++) begin
         wx_d[2*k +: 2] = bus.spike_in[k] ? w_active_q[k] : 2'b00;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         w_shadow_q <= '0;
         w_active_q <= '0;
         wx_q       <= '0;
         wx_valid_q <= 1'b0;
         cfg_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cfg_done_q <= commit;
         wx_valid_q <= bus.spike_valid;
         if (shadow_we) begin
            w_shadow_q[idx_q] <= bus.cfg_data;
         end
         // wx_d reads the pre-commit bank, so a spike on the commit edge sees old weights.
         if (commit) begin
            w_active_q <= w_shadow_q;
         end
         if (bus.spike_valid) begin
            wx_q <= wx_d;
         end
      end
   end

   assign bus.cfg_ready = (state_q == LOAD);
   assign bus.busy      = (state_q != IDLE);
   assign bus.cfg_done  = cfg_done_q;
   assign bus.wx        = wx_q;
   assign bus.wx_valid  = wx_valid_q;
endmodule

// File: tb/tb_synapse_loader.sv
// Directed bench for synapse_loader: reset, load, backpressure, restart, commit/spike overlap, reset mid-load.
module tb_synapse_loader;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   done_seen;

   always #5 clk = ~clk;

   synapse_loader_if #(.N_STAGE(5)) bus ();

   synapse_loader #(.N_STAGE(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Pulse cfg_start, stream 32 weights (optionally with a one-cycle gap before each),
   // then check cfg_done lands exactly one cycle after the last transfer.
   task automatic load_all(input bit use_mod, input logic [1:0] wc, input bit gaps);
      bus.cfg_start = 1'b1;
      step();
      bus.cfg_start = 1'b0;
      bus.cfg_valid = 1'b0;
      chk("load_ready", {63'd0, bus.cfg_ready}, 64'd1);
      for (int k = 0; k < 32; k++) begin
         if (gaps) begin
            bus.cfg_valid = 1'b0;
            step();
         end
         bus.cfg_valid = 1'b1;
         bus.cfg_data  = use_mod ? 2'(k % 4) : wc;
         step();
      end
      bus.cfg_valid = 1'b0;
      chk("commit_busy", {63'd0, bus.busy}, 64'd1);
      chk("commit_no_done", {63'd0, bus.cfg_done}, 64'd0);
      step();
      chk("done_pulse", {63'd0, bus.cfg_done}, 64'd1);
      step();
      chk("done_clear", {63'd0, bus.cfg_done}, 64'd0);
   endtask

   task automatic spike(input logic [31:0] s, input string tag, input logic [63:0] exp);
      bus.spike_valid = 1'b1;
      bus.spike_in    = s;
      step();
      bus.spike_valid = 1'b0;
      chk(tag, bus.wx, exp);
      chk({tag, "_vld"}, {63'd0, bus.wx_valid}, 64'd1);
   endtask

   initial begin
      bus.cfg_start   = 1'b0;
      bus.cfg_valid   = 1'b0;
      bus.cfg_data    = 2'd0;
      bus.spike_valid = 1'b0;
      bus.spike_in    = '0;

      // Reset asserted mid-cycle must clear outputs immediately.
      rst_n = 1'b1;
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_wx", bus.wx, 64'd0);
      chk("rst_wx_valid", {63'd0, bus.wx_valid}, 64'd0);
      chk("rst_cfg_ready", {63'd0, bus.cfg_ready}, 64'd0);
      chk("rst_cfg_done", {63'd0, bus.cfg_done}, 64'd0);
      chk("rst_busy", {63'd0, bus.busy}, 64'd0);
      step();
      step();
      rst_n = 1'b1;
      step();
      spike(32'hFFFF_FFFF, "rst_spike", 64'd0);

      // Basic back-to-back load of k%4.
      load_all(1'b1, 2'd0, 1'b0);
      chk("idle_busy", {63'd0, bus.busy}, 64'd0);
      spike(32'hFFFF_FFFF, "basic_ones", 64'hE4E4_E4E4_E4E4_E4E4);
      spike(32'h0000_FFFF, "basic_half", 64'h0000_0000_E4E4_E4E4);
      step();
      chk("hold_wx", bus.wx, 64'h0000_0000_E4E4_E4E4);
      chk("hold_vld", {63'd0, bus.wx_valid}, 64'd0);

      // Restart after 10 weights of 3; the transfer coincident with the restart is dropped.
      bus.cfg_start = 1'b1;
      step();
      bus.cfg_start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         bus.cfg_valid = 1'b1;
         bus.cfg_data  = 2'd3;
         step();
      end
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = 2'd3;
      load_all(1'b0, 2'd1, 1'b0);
      spike(32'hFFFF_FFFF, "restart_ones", 64'h5555_5555_5555_5555);

      // Backpressured load of k%4 gives the same result as the back-to-back one.
      load_all(1'b1, 2'd0, 1'b1);
      spike(32'hFFFF_FFFF, "bp_ones", 64'hE4E4_E4E4_E4E4_E4E4);

      // Active = all 2s, then load all 1s with spikes during load and on the commit edge.
      load_all(1'b0, 2'd2, 1'b0);
      bus.cfg_start = 1'b1;
      step();
      bus.cfg_start = 1'b0;
      for (int k = 0; k < 32; k++) begin
         bus.cfg_valid   = 1'b1;
         bus.cfg_data    = 2'd1;
         bus.spike_valid = (k == 15);
         bus.spike_in    = 32'hFFFF_FFFF;
         step();
         if (k == 15) begin
            chk("load_spike", bus.wx, 64'hAAAA_AAAA_AAAA_AAAA);
         end
      end
      bus.cfg_valid   = 1'b0;
      bus.spike_valid = 1'b0;
      spike(32'hFFFF_FFFF, "commit_spike", 64'hAAAA_AAAA_AAAA_AAAA);
      chk("commit_done", {63'd0, bus.cfg_done}, 64'd1);
      spike(32'hFFFF_FFFF, "post_commit_spike", 64'h5555_5555_5555_5555);

      // Reset after 20 transfers: no cfg_done, both banks cleared.
      bus.cfg_start = 1'b1;
      step();
      bus.cfg_start = 1'b0;
      for (int k = 0; k < 20; k++) begin
         bus.cfg_valid = 1'b1;
         bus.cfg_data  = 2'd3;
         step();
      end
      bus.cfg_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
      chk("midrst_ready", {63'd0, bus.cfg_ready}, 64'd0);
      chk("midrst_wx", bus.wx, 64'd0);
      step();
      rst_n = 1'b1;
      done_seen = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (bus.cfg_done === 1'b1) done_seen++;
      end
      chk("midrst_no_done", 64'(done_seen), 64'd0);
      chk("midrst_idle", {63'd0, bus.busy}, 64'd0);
      spike(32'hFFFF_FFFF, "midrst_spike", 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/synapse_loader.md
# synapse_loader

Produces the packed weighted-input bus `wx` consumed by the neuron's adder tree. Synapse weights arrive serially over a narrow configuration handshake into a shadow bank, then commit atomically to an active bank. Each presented spike vector is gated against the active weights and registered onto `wx` with a one-cycle valid strobe. The block sits between the chip's configuration/IO path and the adder tree input.

## Interface
- `N_STAGE`, 5, adder-tree depth. Synapse count `N_SYN = 2**N_STAGE` (32). `wx` width is `2*N_SYN` (64).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_start`  in  1  single-cycle pulse; begins or restarts a weight load.
- `cfg_valid`  in  1  `cfg_data` holds a weight.
- `cfg_data`  in  2  unsigned weight, 0..3.
- `cfg_ready`  out  1  block accepts a weight this cycle.
- `cfg_done`  out  1  one-cycle pulse when the active bank has been updated.
- `busy`  out  1  high whenever state is not IDLE.
- `spike_valid`  in  1  `spike_in` is to be sampled this cycle.
- `spike_in`  in  `N_SYN`  one bit per synapse.
- `wx`  out  `2*N_SYN`  `wx[2k+1:2k]` = `spike[k] ? w_active[k] : 2'b00`.
- `wx_valid`  out  1  one-cycle pulse; `wx` was updated at this edge.

## Operation
- Storage: `w_shadow[N_SYN]` and `w_active[N_SYN]`, each 2 bits per synapse. There is also a 0..N_SYN-1 index counter `idx`.
- The FSM has three states: IDLE, LOAD, COMMIT.
  - IDLE: `cfg_ready` = 0. On `cfg_start`: `idx` ← 0, go to LOAD.
  - LOAD: `cfg_ready` = 1. A transfer occurs on any edge with `cfg_valid & cfg_ready`. On a transfer, `w_shadow[idx]` ← `cfg_data` and `idx` increments.
  - The first accepted weight belongs to synapse 0. The transfer with `idx == N_SYN-1` moves the FSM to COMMIT.
  - `cfg_valid` gaps stall the load indefinitely.
  - COMMIT: `cfg_ready` = 0. On the next edge, `w_active` ← `w_shadow`, `cfg_done` is high for that cycle, and the FSM goes to IDLE.
- Restart: `cfg_start` in LOAD sets `idx` ← 0 and the FSM stays in LOAD.
  - The concurrent transfer, if any, is discarded.
  - Partial shadow contents are overwritten by the new load. `w_active` is untouched.
- `cfg_start` in COMMIT is ignored.
- Spike path: it runs independently of the FSM in every state.
  - On an edge with `spike_valid`, `wx` is recomputed from `spike_in` and the current `w_active`, and `wx_valid` ← 1.
  - Otherwise `wx` holds and `wx_valid` ← 0.
- Weights are unsigned. No arithmetic is done here; the maximum adder-tree sum is `3*N_SYN`, which fits its `N_STAGE+2`-bit output.

## Timing
- Reset values (async assert, sync release): state IDLE, `idx` 0, both banks all-zero, `wx` 0. `wx_valid`, `cfg_ready`, `cfg_done` and `busy` are all 0.
- `cfg_ready` and `busy` are decoded from registered state only, with no combinational path from inputs.
- Load timing:
  - Minimum load is `cfg_start` at edge t0, followed by `N_SYN` back-to-back transfers at edges t1..t32.
  - COMMIT occupies the cycle after t32. `w_active` updates and `cfg_done` is high after edge t33.
- Spike latency is 1 edge: `spike_valid` sampled at edge t gives `wx`/`wx_valid` visible after t.
- Simultaneous commit and spike: a spike sampled on the COMMIT edge uses the old `w_active`. The new weights apply from the following edge.
- A spike during LOAD always uses the old `w_active`.
- Reset mid-load: everything returns to reset values. Both banks clear, and no `cfg_done` is produced.

## Test plan
- Reset check: assert `rst_n` = 0 mid-cycle → all outputs read 0 immediately. Then `spike_valid` with `spike_in` = all-ones → `wx` = 0, `wx_valid` pulses.
- Basic load: load `w[k] = k%4` back-to-back, wait for `cfg_done`, then `spike_in` = all-ones → `wx` = 64'hE4E4_E4E4_E4E4_E4E4. Then `spike_in` = 32'h0000_FFFF → `wx` = 64'h0000_0000_E4E4_E4E4.
- Backpressure: the same load with `cfg_valid` toggling every other cycle → `cfg_done` arrives exactly one cycle after the 32nd accepted transfer, and produces an identical `wx` result.
- Restart: load 10 weights of 3, pulse `cfg_start`, then load 32 weights of 1 and commit → all-ones spike gives `wx` = 64'h5555_5555_5555_5555.
- Spike during load and at commit: active bank all 2s, loading all 1s.
  - A spike during LOAD → `wx` = 64'hAAAA_AAAA_AAAA_AAAA.
  - A spike on the COMMIT edge → 64'hAAAA_AAAA_AAAA_AAAA.
  - A spike on the next edge → 64'h5555_5555_5555_5555.
- Reset mid-load: assert reset after 20 transfers → state IDLE and `cfg_done` never pulses. An all-ones spike afterwards gives `wx` = 0.
